// File: rtl/instr_stream_loader.sv
// instr_stream_loader: packs a host byte stream into big-endian words, bursts them into CPU instruction memory, then releases the CPU.
// Define LOADER_CHECKSUM_EN to add a word checksum that blocks the load on mismatch.
module instr_stream_loader #(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic [7:0]    ByteIn,
  input  logic          ByteValid,
  output logic          ByteReady,
  input  logic          LoadDone,
  output logic          CpuReset,
  output logic          LoadInstructions,
  output logic [31:0]   Instruction,
  output logic          Busy,
  output logic [AW:0]   WordsLoaded,
  output logic          Overflow
`ifdef LOADER_CHECKSUM_EN
  ,
  input  logic [31:0]   ExpectedSum,
  output logic [31:0]   Checksum,
  output logic          SumError
`endif
);
  typedef enum logic [2:0] {IDLE, COLLECT, PRELOAD, BURST, RESTART, RUN} state_e;
  state_e      state_q, state_d;
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] word_q, word_d, cur, instr_d;
  logic [AW:0] words_q, words_d;
  logic        ovf_q, ovf_d, ready_d, cpurst_d, load_d, busy_d;
  logic        acc, full_word, commit, start_ok;
  logic [31:0] mem [DEPTH];
`ifdef LOADER_CHECKSUM_EN
  logic [31:0] sum_q, sum_d;
  logic        serr_q, serr_d;
  assign Checksum = sum_q;
  assign SumError = serr_q;
`endif
  assign acc       = state_q == COLLECT && ByteValid && ByteReady;
  assign cur       = acc ? word_q | ({24'd0, ByteIn} << (5'd24 - {cnt_q, 3'd0})) : word_q;
  assign full_word = acc && cnt_q == 2'd3;
  assign commit    = state_q == COLLECT && (full_word || (LoadDone && (cnt_q != 2'd0 || acc)));
  assign start_ok  = Start && (state_q == IDLE || state_q == RUN);
  assign WordsLoaded = words_q;
  assign Overflow    = ovf_q;
  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    words_d = words_q;
    ovf_d   = ovf_q | (state_q == COLLECT && ByteValid && !ByteReady);
`ifdef LOADER_CHECKSUM_EN
    sum_d   = commit ? sum_q + cur : sum_q;
    serr_d  = serr_q;
`endif
    if (commit) begin
      wr_d    = wr_q + AW'(1);
      words_d = words_q + (AW+1)'(1);
      word_d  = '0;
      cnt_d   = '0;
    end else if (acc) begin
      word_d = cur;
      cnt_d  = cnt_q + 2'd1;
    end
    case (state_q)
      IDLE:    state_d = Start ? COLLECT : IDLE;
      COLLECT: if (LoadDone) begin
        state_d = PRELOAD;
`ifdef LOADER_CHECKSUM_EN
        if (sum_d != ExpectedSum) begin
          state_d = IDLE;
          serr_d  = 1'b1;
        end
`endif
      end
      PRELOAD: state_d = words_q == '0 ? RESTART : BURST;
      BURST: begin
        rd_d    = rd_q + AW'(1);
        state_d = ({1'b0, rd_q} + (AW+1)'(1)) == words_q ? RESTART : BURST;
      end
      RESTART: state_d = RUN;
      RUN:     state_d = Start ? COLLECT : RUN;
      default: state_d = IDLE;
    endcase
    if (start_ok) begin
      wr_d    = '0;
      rd_d    = '0;
      cnt_d   = '0;
      word_d  = '0;
      words_d = '0;
      ovf_d   = 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_d   = '0;
      serr_d  = 1'b0;
`endif
    end
    ready_d  = state_d == COLLECT && words_d < (AW+1)'(DEPTH);
    cpurst_d = !(state_d == BURST || state_d == RUN);
    load_d   = state_d == BURST;
    instr_d  = state_d == BURST ? mem[rd_d] : '0;
    busy_d   = state_d inside {COLLECT, PRELOAD, BURST, RESTART};
  end
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q          <= IDLE;
      wr_q             <= '0;
      rd_q             <= '0;
      cnt_q            <= '0;
      word_q           <= '0;
      words_q          <= '0;
      ovf_q            <= 1'b0;
      ByteReady        <= 1'b0;
      CpuReset         <= 1'b1;
      LoadInstructions <= 1'b0;
      Instruction      <= '0;
      Busy             <= 1'b0;
    end else begin
      state_q          <= state_d;
      wr_q             <= wr_d;
      rd_q             <= rd_d;
      cnt_q            <= cnt_d;
      word_q           <= word_d;
      words_q          <= words_d;
      ovf_q            <= ovf_d;
      ByteReady        <= ready_d;
      CpuReset         <= cpurst_d;
      LoadInstructions <= load_d;
      Instruction      <= instr_d;
      Busy             <= busy_d;
    end
  end
`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      sum_q  <= '0;
      serr_q <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      serr_q <= serr_d;
    end
  end
`endif
  // Buffer is written only while collecting and read only while bursting.
  always_ff @(posedge clk) begin
    if (commit) mem[wr_q] <= cur;
  end
endmodule

// File: tb/tb_instr_stream_loader.sv
// tb_instr_stream_loader: directed checks of collect, burst, padding, overflow and empty-load sequencing.
module tb_instr_stream_loader;
  logic        clk = 0, Reset = 1, Start = 0, ByteValid = 0, LoadDone = 0;
  logic [7:0]  ByteIn = 0;
  logic        ByteReady, CpuReset, LoadInstructions, Busy, Overflow;
  logic [31:0] Instruction;
  logic [2:0]  WordsLoaded;
  int          errors = 0, checks = 0;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0] ExpectedSum = 0, Checksum;
  logic        SumError;
`endif
  instr_stream_loader #(.DEPTH(4), .AW(2)) dut (
    .clk(clk), .Reset(Reset), .Start(Start), .ByteIn(ByteIn), .ByteValid(ByteValid),
    .ByteReady(ByteReady), .LoadDone(LoadDone), .CpuReset(CpuReset),
    .LoadInstructions(LoadInstructions), .Instruction(Instruction), .Busy(Busy),
    .WordsLoaded(WordsLoaded), .Overflow(Overflow)
`ifdef LOADER_CHECKSUM_EN
    , .ExpectedSum(ExpectedSum), .Checksum(Checksum), .SumError(SumError)
`endif
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [7:0] b, input logic ld);
    ByteIn = b;
    ByteValid = 1;
    LoadDone = ld;
    tick();
    ByteValid = 0;
    LoadDone = 0;
  endtask
  task automatic pulse_start();
    Start = 1;
    tick();
    Start = 0;
  endtask
  logic [31:0] exp_words [4] = '{32'h01020304, 32'h05060708, 32'h090a0b0c, 32'h0d0e0f10};
  initial begin
    tick();
    chk("rst_cpureset", CpuReset, 1);
    chk("rst_load", LoadInstructions, 0);
    chk("rst_instr", Instruction, 0);
    chk("rst_ready", ByteReady, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_words", WordsLoaded, 0);
    chk("rst_ovf", Overflow, 0);
    Reset = 0;
    pulse_start();
    chk("col_busy", Busy, 1);
    chk("col_ready", ByteReady, 1);
    chk("col_cpureset", CpuReset, 1);
    send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 0);
    chk("col_words1", WordsLoaded, 1);
    #2 Reset = 1;
    #1;
    chk("async_busy", Busy, 0);
    chk("async_words", WordsLoaded, 0);
    chk("async_ready", ByteReady, 0);
    chk("async_cpureset", CpuReset, 1);
    Reset = 0;
    pulse_start();
    send(8'h20, 0); send(8'h08, 0); send(8'h00, 0); send(8'h05, 0);
    pulse_start();
    chk("start_ignored_words", WordsLoaded, 1);
    chk("start_ignored_busy", Busy, 1);
    send(8'h8c, 0); send(8'h01, 0); send(8'h00, 0); send(8'h04, 0);
    chk("two_words", WordsLoaded, 2);
    LoadDone = 1;
    tick();
    LoadDone = 0;
    chk("pre_cpureset", CpuReset, 1);
    chk("pre_load", LoadInstructions, 0);
    tick();
    chk("b0_cpureset", CpuReset, 0);
    chk("b0_load", LoadInstructions, 1);
    chk("b0_instr", Instruction, 32'h20080005);
    tick();
    chk("b1_cpureset", CpuReset, 0);
    chk("b1_instr", Instruction, 32'h8c010004);
    tick();
    chk("rs_cpureset", CpuReset, 1);
    chk("rs_load", LoadInstructions, 0);
    chk("rs_instr", Instruction, 0);
    tick();
    chk("run_cpureset", CpuReset, 0);
    chk("run_busy", Busy, 0);
    pulse_start();
    chk("restart_cpureset", CpuReset, 1);
    chk("restart_words", WordsLoaded, 0);
    send(8'haa, 0);
    send(8'hbb, 1);
    chk("pad_words", WordsLoaded, 1);
    chk("pad_pre_load", LoadInstructions, 0);
    tick();
    chk("pad_instr", Instruction, 32'haabb0000);
    chk("pad_load", LoadInstructions, 1);
    tick();
    chk("pad_rs_load", LoadInstructions, 0);
    chk("pad_rs_cpureset", CpuReset, 1);
    tick();
    chk("pad_run", CpuReset, 0);
    pulse_start();
    for (int i = 1; i <= 20; i++) begin
      ByteIn = 8'(i);
      ByteValid = 1;
      tick();
      if (i == 16) begin
        chk("full_ready", ByteReady, 0);
        chk("full_ovf_pre", Overflow, 0);
      end
    end
    ByteValid = 0;
    chk("ovf_set", Overflow, 1);
    chk("ovf_words", WordsLoaded, 4);
    LoadDone = 1;
    tick();
    LoadDone = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("ovf_burst%0d", k), Instruction, exp_words[k]);
    end
    tick();
    chk("ovf_rs_instr", Instruction, 0);
    chk("ovf_rs_load", LoadInstructions, 0);
    tick();
    pulse_start();
    chk("ovf_cleared", Overflow, 0);
    LoadDone = 1;
    tick();
    LoadDone = 0;
    chk("empty_pre_load", LoadInstructions, 0);
    chk("empty_pre_busy", Busy, 1);
    tick();
    chk("empty_rs_load", LoadInstructions, 0);
    chk("empty_rs_cpureset", CpuReset, 1);
    tick();
    chk("empty_run_cpureset", CpuReset, 0);
    chk("empty_run_busy", Busy, 0);
`ifdef LOADER_CHECKSUM_EN
    ExpectedSum = 32'd4;
    pulse_start();
    send(8'h00, 0); send(8'h00, 0); send(8'h00, 0); send(8'h01, 0);
    send(8'h00, 0); send(8'h00, 0); send(8'h00, 0); send(8'h02, 0);
    chk("sum_value", Checksum, 3);
    LoadDone = 1;
    tick();
    LoadDone = 0;
    chk("sum_err", SumError, 1);
    chk("sum_idle_busy", Busy, 0);
    chk("sum_cpureset", CpuReset, 1);
    tick();
    chk("sum_no_load", LoadInstructions, 0);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/instr_stream_loader.md
Name: instr_stream_loader

Overview:
Upstream boot feeder for the pipelined CPU. It accepts a byte stream from a host over a valid/ready handshake and packs it into 32-bit big-endian words in an internal buffer. It then holds the CPU in reset and bursts the buffered program into instruction memory, one word per cycle, starting at load address 0. Finally it releases the CPU to run. It drives the CPU's Reset, LoadInstructions and Instruction inputs.

Parameters:
DEPTH, 32, buffer capacity in words.
AW, 5, buffer pointer width; log2(DEPTH).

Ports:
clk  input  1  system clock; all state updates on the rising edge.
Reset  input  1  asynchronous, active-high reset.
Start  input  1  pulse; begins a new program load.
ByteIn  input  8  program byte from host.
ByteValid  input  1  ByteIn is valid this cycle.
ByteReady  output  1  loader can accept a byte this cycle.
LoadDone  input  1  pulse; host has sent the last byte.
CpuReset  output  1  drives the CPU Reset input.
LoadInstructions  output  1  drives the CPU LoadInstructions input.
Instruction  output  32  drives the CPU Instruction input.
Busy  output  1  high in COLLECT, PRELOAD, BURST and RESTART.
WordsLoaded  output  AW+1  number of words committed to the buffer.
Overflow  output  1  sticky; a byte was offered while the buffer was full.

Behaviour:
- Reset (async, any state): state=IDLE; CpuReset=1; LoadInstructions=0; Instruction=0; ByteReady=0; WordsLoaded=0; Overflow=0; pointers and byte counter cleared.
- States: IDLE, COLLECT, PRELOAD, BURST, RESTART, RUN.
- IDLE: CpuReset=1. On Start go to COLLECT and clear wr_ptr, rd_ptr, byte count, WordsLoaded and Overflow.
- COLLECT:
  - CpuReset=1.
  - ByteReady=1 iff WordsLoaded<DEPTH.
  - A byte is accepted when ByteValid&&ByteReady. The first byte of a word goes to [31:24], then [23:16], [15:8], [7:0].
  - On the 4th byte the word is written to buf[wr_ptr]; wr_ptr and WordsLoaded increment.
  - ByteValid while full: the byte is dropped and Overflow is set.
  - Start is ignored while in COLLECT.
- LoadDone in COLLECT:
  - If a byte is accepted in the same cycle, that byte is taken first.
  - If a partial word remains (1–3 bytes), its unused low bytes are zero-padded and it is committed, provided space remains.
  - Next state is PRELOAD.
- PRELOAD (1 cycle): CpuReset=1, LoadInstructions=0. This clears the CPU load-address counter to 0.
  - Next state is BURST, or RESTART if WordsLoaded==0.
- BURST (WordsLoaded cycles):
  - CpuReset=0, LoadInstructions=1, Instruction=buf[rd_ptr]; rd_ptr increments each cycle.
  - Cycle k presents word k, which the CPU writes at load address k.
  - Words are presented contiguously with no gaps.
  - After the last word, next state is RESTART.
- RESTART (1 cycle): CpuReset=1, LoadInstructions=0, Instruction=0. This resets the PC and flushes the pipeline.
- RUN: CpuReset=0, LoadInstructions=0. A Start pulse reasserts CpuReset and goes to COLLECT.
- Timing: with LoadDone seen in cycle t, PRELOAD is at t+1, BURST spans t+2..t+1+N, RESTART is at t+2+N, and the CPU runs from t+3+N.
- Outputs are registered. Instruction=0 outside BURST.
- Buffer: DEPTH x 32 register array, write-then-read only; there is never a simultaneous read and write.
- Reset in mid-burst aborts to IDLE; buffer contents become don't-care.

Optional Feature:
Macro: LOADER_CHECKSUM_EN.
- With the macro defined:
  - Extra input ExpectedSum[31:0] and extra outputs Checksum[31:0] and SumError.
  - Checksum is the modulo-2^32 sum of the committed words (padded word included); it is cleared on Start.
  - At the LoadDone commit, if Checksum!=ExpectedSum, SumError is set. The FSM then goes to IDLE instead of PRELOAD, so the CPU stays in reset.
  - SumError is cleared by Start or Reset.
- Without the macro: these ports and this logic are absent, and LoadDone always proceeds to PRELOAD.

Test Plan:
- Reset mid-COLLECT -> all outputs return to reset values immediately (async); CpuReset=1.
- Start; 8 bytes 20,08,00,05,8C,01,00,04; LoadDone -> WordsLoaded=2. BURST presents 0x20080005, then 0x8C010004. CpuReset pattern: 1 (PRELOAD), 0, 0 (BURST), 1 (RESTART), 0 (RUN).
- Start; bytes AA,BB; LoadDone in the same cycle as BB -> one padded word 0xAABB0000; BURST lasts 1 cycle.
- DEPTH=4; 20 bytes offered -> ByteReady=0 after byte 16; Overflow=1; WordsLoaded=4; bytes 17–20 never appear.
- Start then immediate LoadDone -> PRELOAD, then RESTART; LoadInstructions never asserted; RUN after 3 cycles.
- With LOADER_CHECKSUM_EN, words 1,2 and ExpectedSum=4 -> SumError=1; state returns to IDLE; LoadInstructions never asserted.
